sha256_msg_feeder: RTL and testbench
====================================

# sha256_msg_feeder

Upstream feeder for the SHA256 core. Accepts a message as a stream of 32-bit big-endian words, buffers up to 29 words, applies SHA-256 padding and the 64-bit bit-length, and drives the core's `start`/`msg`/`blk_type` inputs for one or two 512-bit blocks. It tracks the core's `blk_done` pulses, swaps in the second block between blocks, and returns the final digest with a one-cycle valid strobe.

## Interface
- `MAX_WORDS`, default 29: maximum accepted message length in words. Legal range is 1..29.
- `CLK` in 1: clock.
- `nreset` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: an input word is offered.
- `in_ready` out 1: the feeder accepts a word this cycle. A word transfers when `in_valid & in_ready`.
- `in_data` in 32: message word. The first word transferred is message word 0.
- `in_last` in 1: marks the final word of the message.
- `sha_start` out 1: start pulse to the core.
- `sha_msg` out 512: current block. Word i sits at bits [511-32i : 480-32i].
- `sha_blk_type` out 2: block type to the core. HASH=0 selects one block; MERKLE_LEAF=1 or HEADER=2 selects two blocks.
- `sha_hash` in 256: core hash output.
- `sha_blk_done` in 1: core block-done pulse.
- `digest` out 256: final hash, held until the next digest.
- `digest_valid` out 1: one-cycle strobe when `digest` updates.
- `len_err` out 1: one-cycle strobe when a message is discarded for overflow.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, LOAD, PAD, START, RUN.
- **IDLE / LOAD**
  - `in_ready`=1. Each accepted word is written to `buf[cnt]` and `cnt` increments.
  - An accepted word moves IDLE to LOAD, or to PAD if `in_last` is set.
  - An accepted word with `in_last` moves LOAD to PAD and records `len` = `cnt` + 1.
  - If a word is accepted with `cnt`==MAX_WORDS-1 and `in_last` low, the feeder pulses `len_err`, clears `cnt`, goes to IDLE, and never asserts `sha_start`.
- **Block count:** `nblk` = 1 if `len` ≤ 13, otherwise 2.
- **Padded message**, word index p in 0..(16·nblk − 1):
  - p < len: `buf[p]`.
  - p == len: 0x80000000.
  - p == 16·nblk − 1: `len`·32.
  - otherwise: 0. This includes the upper length word at index 16·nblk − 2.
- **PAD:** `sha_msg` ← block 0 (padded words 0..15). `sha_blk_type` ← HASH if nblk=1; MERKLE_LEAF if `len`=16; HEADER otherwise. `sha_start` ← 1. Next state is START.
- **START:** `sha_start` ← 0. Next state is RUN. `sha_start` is high for exactly one cycle.
- **RUN:**
  - `in_ready`=0 and `sha_blk_type` is held.
  - On a sampled `sha_blk_done`=1 with nblk=2 and `blk_idx`=0: `sha_msg` ← block 1 (padded words 16..31) on that same edge, and `blk_idx` ← 1.
  - On a sampled `sha_blk_done`=1 in any other case: `digest` ← `sha_hash`, `digest_valid` ← 1 for one cycle, `cnt` and `blk_idx` cleared, next state IDLE.
- **Arithmetic:** all modulo 32 bits. The length word is `len`<<5, at most 928.
- **Reset:** an asserted reset mid-operation forces IDLE and clears the buffer count. The core shares the same reset, so no partial hash is reported.

## Timing
- **Reset values:** `in_ready`=0 while reset is asserted, 1 once in IDLE. `sha_start`=0, `sha_msg`=0, `sha_blk_type`=0, `digest`=0, `digest_valid`=0, `len_err`=0, `busy`=0.
- **Start sequence:** the last word is accepted at edge N. `sha_msg`, `sha_blk_type` and `sha_start` become valid at edge N+1. The core samples `start` at edge N+2 and latches `msg` at edge N+3. `sha_msg` stays stable until the next block swap.
- **Block swap:** the swap must land on the edge that samples `sha_blk_done`=1. The core latches the second block two edges later (after its WAIT_ONE_CLOCK → INI sequence), so there is no later opportunity.
- **Digest timing:** `digest_valid` rises one edge after the final `sha_blk_done` is sampled. The earliest next word acceptance is the edge after that.
- **Back-pressure:** `in_valid` with `in_ready`=0 transfers nothing and has no effect.

## Structure
- **`sha256_pkg`** holds:
  - the blk_type codes HASH, MERKLE_LEAF and HEADER;
  - the default MAX_WORDS;
  - PAD_WORD = 0x80000000;
  - ONE_BLK_MAX = 13;
  - the state encodings.
- **`sha256_pad_block`** is the one sub-module: a combinational padded 16-word block former.
  - Inputs: `buf`, `len`, `nblk`, block index.
  - Output: a 512-bit block.
  - It is instantiated once, with its block-index input muxed.

## Test plan
- **One-word message:** send 0x61626364 with `in_last` ("abcd").
  - `sha_msg` = 0x61626364_80000000, then zeros, with 0x00000020 as the last word; `sha_blk_type`=0.
  - After the core finishes, `digest` = 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589.
- **20-word header (words 0x00000001..0x00000014):**
  - Block 0 = words 1..16, `sha_blk_type`=2.
  - Block 1 = 0x11..0x14, 0x80000000, zeros, last word 0x00000280; it is presented on the first `sha_blk_done` edge.
  - `digest` matches the software model, and there is exactly one `digest_valid`.
- **16-word Merkle leaf:**
  - `sha_blk_type`=1.
  - Block 1 = 0x80000000, 14 zeros, 0x00000200.
- **13- vs 14-word boundary:**
  - 13 words gives a single block with 0x80000000 at word 13 and 0x000001A0 at word 15.
  - 14 words gives two blocks, with block 0 word 14 = 0x80000000 and block 1 word 15 = 0x000001C0.
- **Overflow:** 29 words with `in_last` low.
  - `len_err` pulses on the 29th word, `sha_start` never rises, and the next message is processed normally.
- **Reset mid-run:** drop `nreset` during RUN of a two-block message.
  - All outputs take their reset values, no `digest_valid` is seen, and a fresh message completes correctly.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, block-type codes and feeder state encoding for the
// SHA-256 message feeder slice.
package sha256_pkg;

  localparam int          DEF_MAX_WORDS = 29;
  localparam int          LEN_W         = 5;
  localparam int          ONE_BLK_MAX   = 13;
  localparam logic [31:0] PAD_WORD      = 32'h8000_0000;

  typedef enum logic [1:0] {
    HASH        = 2'd0,
    MERKLE_LEAF = 2'd1,
    HEADER      = 2'd2
  } blk_type_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PAD   = 3'd2,
    START = 3'd3,
    RUN   = 3'd4
  } state_e;

endpackage

// File: rtl/sha256_pad_block.sv
// Combinational former for one 16-word block of the padded message:
// data words, the 0x80000000 marker, zeros, then the bit length last.
module sha256_pad_block
  import sha256_pkg::*;
#(
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic [MAX_WORDS-1:0][31:0] i_buf,
  input  logic [LEN_W-1:0]           i_len,
  input  logic                       i_nblk,
  input  logic                       i_blk_idx,
  output logic [511:0]               o_block
);

  logic [LEN_W-1:0] w_last_idx;
  logic [31:0]      w_len_bits;

  // i_nblk: 0 = one block, 1 = two blocks
  assign w_last_idx = i_nblk ? 5'd31 : 5'd15;
  assign w_len_bits = {{(32-LEN_W-5){1'b0}}, i_len, 5'b0};

  for (genvar gi = 0; gi < 16; gi++) begin : g_word
    logic [LEN_W-1:0] w_p;
    logic [31:0]      w_word;

    assign w_p = {i_blk_idx, 4'(gi)};

    always_comb begin
      w_word = 32'h0;
      if (w_p < i_len)
        w_word = i_buf[w_p];
      else if (w_p == i_len)
        w_word = PAD_WORD;
      else if (w_p == w_last_idx)
        w_word = w_len_bits;
    end

    assign o_block[511-32*gi -: 32] = w_word;
  end

endmodule

// File: rtl/sha256_msg_feeder.sv
// Buffers a word-stream message, pads it into one or two SHA-256 blocks,
// sequences the core through them and returns the final digest.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic         CLK,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic         sha_start,
  output logic [511:0] sha_msg,
  output logic [1:0]   sha_blk_type,
  input  logic [255:0] sha_hash,
  input  logic         sha_blk_done,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         len_err,
  output logic         busy
);

  state_e                     r_state;
  state_e                     w_state_next;
  logic [MAX_WORDS-1:0][31:0] r_buf;
  logic [LEN_W-1:0]           r_cnt;
  logic [LEN_W-1:0]           r_len;
  logic                       r_blk_idx;
  logic [511:0]               r_sha_msg;
  blk_type_e                  r_sha_blk_type;
  logic                       r_sha_start;
  logic [255:0]               r_digest;
  logic                       r_digest_valid;
  logic                       r_len_err;

  logic                       w_loading;
  logic                       w_accept;
  logic                       w_overflow;
  logic                       w_nblk;
  logic                       w_swap;
  logic                       w_finish;
  logic                       w_pad_idx;
  logic [511:0]               w_block;

  assign w_loading  = (r_state == IDLE) || (r_state == LOAD);
  assign in_ready   = w_loading & nreset;
  assign w_accept   = in_valid & in_ready;
  assign w_overflow = w_accept & ~in_last & (r_cnt == LEN_W'(MAX_WORDS - 1));
  assign w_nblk     = (r_len > LEN_W'(ONE_BLK_MAX));
  // Second block must be on sha_msg at the very edge that sees blk_done.
  assign w_swap     = (r_state == RUN) & sha_blk_done & w_nblk & ~r_blk_idx;
  assign w_finish   = (r_state == RUN) & sha_blk_done & ~w_swap;
  assign w_pad_idx  = (r_state == RUN);

  sha256_pad_block #(
    .MAX_WORDS (MAX_WORDS)
  ) u_pad (
    .i_buf     (r_buf),
    .i_len     (r_len),
    .i_nblk    (w_nblk),
    .i_blk_idx (w_pad_idx),
    .o_block   (w_block)
  );

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, LOAD: begin
        if (w_accept) begin
          if (in_last)         w_state_next = PAD;
          else if (w_overflow) w_state_next = IDLE;
          else                 w_state_next = LOAD;
        end
      end
      PAD:     w_state_next = START;
      START:   w_state_next = RUN;
      RUN:     if (w_finish) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_accept) r_buf[r_cnt] <= in_data;
  end

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      r_cnt          <= '0;
      r_len          <= '0;
      r_blk_idx      <= 1'b0;
      r_sha_msg      <= '0;
      r_sha_blk_type <= HASH;
      r_sha_start    <= 1'b0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      r_len_err      <= 1'b0;
    end else begin
      r_sha_start    <= 1'b0;
      r_digest_valid <= 1'b0;
      r_len_err      <= 1'b0;
      if (w_accept) begin
        if (w_overflow) begin
          r_cnt     <= '0;
          r_len_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (in_last) r_len <= r_cnt + 1'b1;
        end
      end
      if (r_state == PAD) begin
        r_sha_msg   <= w_block;
        r_sha_start <= 1'b1;
        if (!w_nblk)                     r_sha_blk_type <= HASH;
        else if (r_len == LEN_W'(16))    r_sha_blk_type <= MERKLE_LEAF;
        else                             r_sha_blk_type <= HEADER;
      end
      if (w_swap) begin
        r_sha_msg <= w_block;
        r_blk_idx <= 1'b1;
      end
      if (w_finish) begin
        r_digest       <= sha_hash;
        r_digest_valid <= 1'b1;
        r_cnt          <= '0;
        r_blk_idx      <= 1'b0;
      end
    end
  end

  assign sha_start    = r_sha_start;
  assign sha_msg      = r_sha_msg;
  assign sha_blk_type = r_sha_blk_type;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;
  assign len_err      = r_len_err;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for the message feeder: a behavioural SHA-256 core with real
// compression answers the feeder; expectations come from standard padding.
module tb_sha256_msg_feeder;

  logic         CLK = 1'b0;
  logic         nreset;
  logic         in_valid, in_ready, in_last;
  logic [31:0]  in_data;
  logic         sha_start, sha_blk_done;
  logic [511:0] sha_msg;
  logic [1:0]   sha_blk_type;
  logic [255:0] sha_hash, digest;
  logic         digest_valid, len_err, busy;

  sha256_msg_feeder dut (
    .CLK(CLK), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .sha_start(sha_start),
    .sha_msg(sha_msg), .sha_blk_type(sha_blk_type), .sha_hash(sha_hash),
    .sha_blk_done(sha_blk_done), .digest(digest), .digest_valid(digest_valid),
    .len_err(len_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  int chk = 0, pass = 0;
  int cyc = 0, dv_cnt = 0, start_cnt = 0, lerr_cnt = 0;
  logic [31:0]  msg_w [32];
  logic [511:0] exp_blk [2];
  logic [1:0]   exp_type;
  logic [255:0] exp_digest;
  int           exp_nb;
  logic [511:0] core_blk1, last_blk0;
  int           core_blocks = 0, done_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (digest_valid) dv_cnt    <= dv_cnt + 1;
    if (sha_start)    start_cnt <= start_cnt + 1;
    if (len_err)      lerr_cnt  <= lerr_cnt + 1;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7] + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
  endfunction

  // Behavioural core: sees start, latches msg one edge later, answers after a
  // random latency, and for two-block jobs latches block 1 two edges after blk_done.
  initial begin : core
    int st, lat, nb, idx;
    logic [255:0] hh;
    st = 0; lat = 0; nb = 1; idx = 0; hh = IV;
    sha_blk_done = 1'b0;
    sha_hash = '0;
    forever begin
      @(negedge CLK);
      sha_blk_done = 1'b0;
      if (!nreset) begin
        st = 0;
        sha_hash = '0;
      end else begin
        case (st)
          0: if (sha_start) begin
               nb = (sha_blk_type == 2'd0) ? 1 : 2;
               idx = 0; hh = IV; core_blocks = 0; st = 1;
             end
          1: begin
               hh = sha256_compress(hh, sha_msg);
               core_blocks++;
               lat = $urandom_range(2, 8);
               st = 2;
             end
          2: if (lat > 1) lat--;
             else begin
               sha_hash = hh;
               sha_blk_done = 1'b1;
               if (idx == 0 && nb == 2) begin idx = 1; st = 3; end
               else begin done_cyc = cyc; st = 0; end
             end
          3: begin core_blk1 = sha_msg; st = 1; end
          default: st = 0;
        endcase
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_expected(input int n);
    logic [31:0]  pw [32];
    logic [255:0] h;
    for (int p = 0; p < 32; p++) pw[p] = (p < n) ? msg_w[p] : 32'h0;
    pw[n] = 32'h8000_0000;
    exp_nb = (n * 32 + 65 + 511) / 512;
    pw[16*exp_nb-1] = 32'(n * 32);
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) exp_blk[b][511-32*i -: 32] = pw[16*b+i];
    exp_type = (exp_nb == 1) ? 2'd0 : (n == 16) ? 2'd1 : 2'd2;
    h = IV;
    for (int b = 0; b < exp_nb; b++) h = sha256_compress(h, exp_blk[b]);
    exp_digest = h;
  endtask

  // Offers msg_w[0..n-1] with random gaps; returns on the negedge after the final transfer.
  task automatic send_words(input int n, input bit last_flag, input string name);
    int idx, guard;
    bit offered_ok;
    idx = 0; guard = 0; offered_ok = 0;
    while (idx < n) begin
      @(negedge CLK);
      guard++;
      if (offered_ok) idx++;
      if (idx == n) break;
      if (guard > 2000) begin
        chk++;
        $display("FAIL %s send timeout: sent %0d words, required %0d", name, idx, n);
        break;
      end
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_data = $urandom; in_last = 1'b0; offered_ok = 0;
      end else begin
        in_valid = 1'b1; in_data = msg_w[idx];
        in_last = last_flag && (idx == n - 1);
        offered_ok = in_ready;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic do_message(input int n, input string name);
    int g, dv0;
    build_expected(n);
    send_words(n, 1'b1, name);
    @(negedge CLK);
    last_blk0 = sha_msg;
    chk++; if (sha_start !== 1'b1) $display("FAIL %s start: got %b required 1", name, sha_start); else pass++;
    chk++; if (sha_msg !== exp_blk[0]) $display("FAIL %s blk0: got %h required %h", name, sha_msg, exp_blk[0]); else pass++;
    chk++; if (sha_blk_type !== exp_type) $display("FAIL %s blk_type: got %0d required %0d", name, sha_blk_type, exp_type); else pass++;
    @(negedge CLK);
    chk++; if (sha_start !== 1'b0) $display("FAIL %s start_len: got %b required 0", name, sha_start); else pass++;
    dv0 = dv_cnt;
    g = 0;
    while (!digest_valid && g < 400) begin
      in_valid = $urandom_range(0, 1); in_data = $urandom; in_last = $urandom_range(0, 1);
      @(negedge CLK);
      g++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk++; if (digest_valid !== 1'b1) $display("FAIL %s digest_timeout: got %b required 1", name, digest_valid); else pass++;
    chk++; if (digest !== exp_digest) $display("FAIL %s digest: got %h required %h", name, digest, exp_digest); else pass++;
    chk++; if (cyc !== done_cyc + 1) $display("FAIL %s digest_latency: got cycle %0d required %0d", name, cyc, done_cyc + 1); else pass++;
    chk++; if (core_blocks !== exp_nb) $display("FAIL %s nblk: got %0d required %0d", name, core_blocks, exp_nb); else pass++;
    if (exp_nb == 2) begin
      chk++; if (core_blk1 !== exp_blk[1]) $display("FAIL %s blk1_at_swap: got %h required %h", name, core_blk1, exp_blk[1]); else pass++;
    end
    @(negedge CLK);
    chk++; if (digest_valid !== 1'b0) $display("FAIL %s dv_width: got %b required 0", name, digest_valid); else pass++;
    chk++; if (in_ready !== 1'b1) $display("FAIL %s ready_after: got %b required 1", name, in_ready); else pass++;
    @(negedge CLK);
    chk++; if (dv_cnt !== dv0 + 1) $display("FAIL %s dv_count: got %0d required %0d", name, dv_cnt - dv0, 1); else pass++;
    $display("msg %s len=%0d nblk=%0d digest=%h", name, n, exp_nb, digest);
  endtask

  task automatic test_reset();
    nreset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) @(negedge CLK);
    chk++; if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b required 0", in_ready); else pass++;
    chk++; if ({sha_start, digest_valid, len_err, busy} !== 4'b0) $display("FAIL reset strobes: got %b required 0000", {sha_start, digest_valid, len_err, busy}); else pass++;
    chk++; if (sha_msg !== '0) $display("FAIL reset sha_msg: got %h required 0", sha_msg); else pass++;
    chk++; if ({sha_blk_type, digest} !== '0) $display("FAIL reset type_digest: got %h required 0", {sha_blk_type, digest}); else pass++;
    nreset = 1'b1;
    @(negedge CLK);
    chk++; if (in_ready !== 1'b1) $display("FAIL reset idle_ready: got %b required 1", in_ready); else pass++;
    $display("reset: in_ready=%b busy=%b", in_ready, busy);
  endtask

  task automatic test_one_word();
    msg_w[0] = 32'h61626364;
    do_message(1, "abcd");
    chk++; if (digest !== 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589)
      $display("FAIL abcd known_digest: got %h", digest); else pass++;
    chk++; if (last_blk0 !== {32'h61626364, 32'h80000000, 416'h0, 32'h20})
      $display("FAIL abcd known_blk0: got %h", last_blk0); else pass++;
  endtask

  task automatic test_header20();
    for (int i = 0; i < 20; i++) msg_w[i] = 32'(i + 1);
    do_message(20, "header20");
    chk++; if (sha_msg !== {32'h11, 32'h12, 32'h13, 32'h14, 32'h80000000, 320'h0, 32'h280})
      $display("FAIL header20 known_blk1: got %h", sha_msg); else pass++;
  endtask

  task automatic test_merkle16();
    for (int i = 0; i < 16; i++) msg_w[i] = $urandom;
    do_message(16, "merkle16");
    chk++; if (sha_msg !== {32'h80000000, 448'h0, 32'h200})
      $display("FAIL merkle16 known_blk1: got %h", sha_msg); else pass++;
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 13; i++) msg_w[i] = $urandom;
    do_message(13, "len13");
    chk++; if ({last_blk0[95:64], last_blk0[31:0]} !== {32'h80000000, 32'h1A0})
      $display("FAIL len13 words13_15: got %h required 80000000000001a0", {last_blk0[95:64], last_blk0[31:0]}); else pass++;
    for (int i = 0; i < 14; i++) msg_w[i] = $urandom;
    do_message(14, "len14");
    chk++; if ({last_blk0[63:32], sha_msg[31:0]} !== {32'h80000000, 32'h1C0})
      $display("FAIL len14 pad_and_len: got %h required 80000000000001c0", {last_blk0[63:32], sha_msg[31:0]}); else pass++;
    for (int i = 0; i < 29; i++) msg_w[i] = $urandom;
    do_message(29, "len29");
  endtask

  task automatic test_overflow();
    int s0, e0;
    for (int i = 0; i < 29; i++) msg_w[i] = $urandom;
    s0 = start_cnt; e0 = lerr_cnt;
    send_words(29, 1'b0, "overflow");
    chk++; if (len_err !== 1'b1) $display("FAIL overflow len_err: got %b required 1", len_err); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL overflow busy: got %b required 0", busy); else pass++;
    repeat (5) @(negedge CLK);
    chk++; if (lerr_cnt !== e0 + 1) $display("FAIL overflow len_err_count: got %0d required 1", lerr_cnt - e0); else pass++;
    chk++; if (start_cnt !== s0) $display("FAIL overflow no_start: got %0d starts required 0", start_cnt - s0); else pass++;
    $display("overflow: len_err pulses=%0d starts=%0d", lerr_cnt - e0, start_cnt - s0);
    for (int i = 0; i < 5; i++) msg_w[i] = $urandom;
    do_message(5, "after_overflow");
  endtask

  task automatic test_reset_mid_run();
    int dv0;
    for (int i = 0; i < 20; i++) msg_w[i] = $urandom;
    send_words(20, 1'b1, "mid_reset");
    repeat (5) @(negedge CLK);
    chk++; if (busy !== 1'b1) $display("FAIL mid_reset busy_before: got %b required 1", busy); else pass++;
    dv0 = dv_cnt;
    nreset = 1'b0;
    #1;
    chk++; if ({in_ready, sha_start, busy, digest_valid, len_err} !== 5'b0)
      $display("FAIL mid_reset strobes: got %b required 00000", {in_ready, sha_start, busy, digest_valid, len_err}); else pass++;
    chk++; if ({sha_msg, sha_blk_type, digest} !== '0) $display("FAIL mid_reset data: got nonzero msg/type/digest"); else pass++;
    repeat (3) @(negedge CLK);
    nreset = 1'b1;
    repeat (20) @(negedge CLK);
    chk++; if (dv_cnt !== dv0) $display("FAIL mid_reset no_digest: got %0d pulses required 0", dv_cnt - dv0); else pass++;
    $display("mid_reset: busy=%b digest_pulses=%0d", busy, dv_cnt - dv0);
    for (int i = 0; i < 20; i++) msg_w[i] = $urandom;
    do_message(20, "after_reset");
  endtask

  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 29);
      for (int i = 0; i < n; i++) msg_w[i] = $urandom;
      do_message(n, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_header20();
    test_merkle16();
    test_boundary();
    test_overflow();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
